issue_scheduler: RTL and testbench
==================================

# issue_scheduler

In-order issue controller that sits between the dispatch queue and the execution units. Each cycle it inspects the queue head, checks register hazards against an internal scoreboard and checks functional-unit availability, then pops and issues at most one instruction. It also drains the queue on a pipeline flush and keeps saturating stall counters for performance analysis.

## Interface

Parameters:
- NUM_REGS, 32, architectural registers tracked by the scoreboard (x0 never busy)
- MUL_LAT, 3, multiplier occupancy in cycles after issue (iterative, non-pipelined unit), ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- q_empty  in  1  dispatch queue empty
- q_instr  in  decoded_instr_t  dispatch queue head, valid combinationally whenever !q_empty
- q_r_en  out  1  pop request to dispatch queue (combinational)
- flush  in  1  pipeline flush request, level
- lsu_ready  in  1  load/store unit can accept an op this cycle
- wb0_valid, wb0_rd  in  1, $clog2(NUM_REGS)  writeback port 0 (ALU/MUL)
- wb1_valid, wb1_rd  in  1, $clog2(NUM_REGS)  writeback port 1 (LSU)
- issue_valid  out  1  registered issue strobe
- issue_instr  out  decoded_instr_t  registered issued instruction
- issue_fu  out  2  registered target unit: 0 ALU, 1 MUL, 2 LSU
- stall_raw_cnt  out  16  cycles stalled on register hazard, saturating
- stall_fu_cnt  out  16  cycles stalled on unit busy, saturating

decoded_instr_t fields used: rs1, rs2, rd, rd_wen, fu_sel[1:0] (same encoding as issue_fu; 3 = illegal).

## Operation

- States: RUN, FLUSH. Reset → RUN.
- RUN → FLUSH when flush=1. FLUSH → RUN when flush=0 and q_empty=1 in the same cycle.
- FLUSH: q_r_en = !q_empty every cycle; nothing issued; stall counters hold; scoreboard and MUL counter keep running (in-flight ops still write back).
- Scoreboard: busy[NUM_REGS] bits. At issue with rd_wen=1 and rd≠0, set busy[rd]. wbN_valid clears busy[wbN_rd]. Register 0 is never set.
- Source ready: busy[rs1]=0 and busy[rs2]=0 (RAW). Destination ready: rd_wen=0 or busy[rd]=0 (WAW).
- Writeback bypass: a register being cleared by either wb port in cycle N counts as not busy for the cycle-N decision.
- Set and clear of the same register in the same cycle: set wins.
- Unit ready: ALU always; MUL when mul_cnt=0; LSU when lsu_ready=1; fu_sel=3 never ready (queue stalls permanently until flush).
- can_issue = RUN && !flush && !q_empty && src_ready && dst_ready && unit_ready. q_r_en = can_issue in RUN.
- MUL counter: loaded with MUL_LAT on MUL issue, decrements to 0 each cycle, holds at 0.
- Stall accounting (RUN, !flush, !q_empty, !can_issue): RAW/WAW failure increments stall_raw_cnt (priority); otherwise unit-not-ready increments stall_fu_cnt. Both saturate at 0xFFFF.

## Timing

- Decision and pop in cycle N; issue_valid/issue_instr/issue_fu asserted in cycle N+1 for exactly one cycle per pop.
- Back-to-back issue: one instruction per cycle when independent.
- Dependent instruction after an ALU op issued in N cannot issue before the cycle its writeback is presented (bypass allows same-cycle issue).
- MUL issued in cycle N: next MUL earliest in cycle N+MUL_LAT+1.
- flush asserted in cycle N: no pop-for-issue in N; issue_valid=0 in N+1 (an issue decided in N−1 still appears in N).
- Reset values: state RUN, busy all 0, mul_cnt 0, issue_valid 0, issue_instr 0, issue_fu 0, both counters 0, q_r_en 0 (combinational from reset state with q_empty).
- Reset mid-operation clears scoreboard regardless of pending writebacks.

## Test plan

- Independent ALU ops: 4 queued with rd=1..4, rs=0 → q_r_en high 4 consecutive cycles, issue_valid high cycles 1–4, stall counters 0.
- RAW: add rd=5 then add rs1=5; wb0 rd=5 presented 3 cycles after first issue → second issues in that wb cycle, stall_raw_cnt=2.
- MUL structural: 2 MULs, MUL_LAT=3, no dependencies → second issue 4 cycles after first, stall_fu_cnt=3.
- LSU backpressure: load at head, lsu_ready low 5 cycles → no pop, stall_fu_cnt=5, issues cycle after lsu_ready rises.
- Flush: 6 entries queued, flush high 2 cycles → queue drained by 6 pops, issue_valid 0 throughout, return to RUN when empty and flush low.
- Saturation/x0: force 70000 stall cycles → stall_raw_cnt=0xFFFF; issue with rd=0, rd_wen=1 → busy[0] stays 0.

Source files
------------

// File: rtl/issue_scheduler.sv
// In-order single-issue controller: scoreboard hazard checks, unit availability,
// flush drain of the dispatch queue and saturating stall counters.
package issue_scheduler_pkg;
  localparam int REG_W = 5;
  typedef struct packed {
    logic [7:0]       op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rd_wen;
    logic [1:0]       fu_sel;
  } decoded_instr_t;
endpackage

module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MUL_LAT  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        q_empty,
  input  decoded_instr_t              q_instr,
  output logic                        q_r_en,
  input  logic                        flush,
  input  logic                        lsu_ready,
  input  logic                        wb0_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb0_rd,
  input  logic                        wb1_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb1_rd,
  output logic                        issue_valid,
  output decoded_instr_t              issue_instr,
  output logic [1:0]                  issue_fu,
  output logic [15:0]                 stall_raw_cnt,
  output logic [15:0]                 stall_fu_cnt
);
  localparam int RW  = $clog2(NUM_REGS);
  localparam int MCW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_LSU = 2'd2;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t              state_r;
  logic [NUM_REGS-1:0] busy_r;
  logic [MCW-1:0]      mul_cnt_r;

  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] busy_eff_s;
  logic                src_ready_s;
  logic                dst_ready_s;
  logic                unit_ready_s;
  logic                run_s;
  logic                can_issue_s;
  logic                stall_s;

  // Issue decision; writebacks in flight this cycle already count as not busy.
  always_comb begin
    clr_mask_s = '0;
    set_mask_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      clr_mask_s[i] = (wb0_valid && (wb0_rd == RW'(i))) || (wb1_valid && (wb1_rd == RW'(i)));
    end
    busy_eff_s  = busy_r & ~clr_mask_s;
    src_ready_s = ~busy_eff_s[q_instr.rs1] & ~busy_eff_s[q_instr.rs2];
    dst_ready_s = ~q_instr.rd_wen | ~busy_eff_s[q_instr.rd];
    case (q_instr.fu_sel)
      FU_ALU:  unit_ready_s = 1'b1;
      FU_MUL:  unit_ready_s = (mul_cnt_r == '0);
      FU_LSU:  unit_ready_s = lsu_ready;
      default: unit_ready_s = 1'b0;
    endcase
    run_s       = (state_r == ST_RUN);
    can_issue_s = run_s & ~flush & ~q_empty & src_ready_s & dst_ready_s & unit_ready_s;
    stall_s     = run_s & ~flush & ~q_empty & ~can_issue_s;
    q_r_en      = run_s ? can_issue_s : ~q_empty;
    for (int i = 1; i < NUM_REGS; i++) begin
      set_mask_s[i] = can_issue_s && q_instr.rd_wen && (q_instr.rd == RW'(i));
    end
  end

  // FSM, scoreboard, MUL occupancy, issue register and stall counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      busy_r        <= '0;
      mul_cnt_r     <= '0;
      issue_valid   <= 1'b0;
      issue_instr   <= '0;
      issue_fu      <= 2'd0;
      stall_raw_cnt <= 16'd0;
      stall_fu_cnt  <= 16'd0;
    end else begin
      case (state_r)
        ST_RUN:   state_r <= flush ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_r <= (!flush && q_empty) ? ST_RUN : ST_FLUSH;
        default:  state_r <= ST_RUN;
      endcase

      // A set for the issuing rd overrides a same-cycle writeback clear.
      busy_r <= busy_eff_s | set_mask_s;

      if (can_issue_s && (q_instr.fu_sel == FU_MUL)) begin
        mul_cnt_r <= MCW'(MUL_LAT);
      end else if (mul_cnt_r != '0) begin
        mul_cnt_r <= mul_cnt_r - MCW'(1);
      end else begin
        mul_cnt_r <= mul_cnt_r;
      end

      issue_valid <= can_issue_s;
      if (can_issue_s) begin
        issue_instr <= q_instr;
        issue_fu    <= q_instr.fu_sel;
      end else begin
        issue_instr <= issue_instr;
        issue_fu    <= issue_fu;
      end

      if (stall_s && !(src_ready_s && dst_ready_s)) begin
        if (stall_raw_cnt != 16'hFFFF) stall_raw_cnt <= stall_raw_cnt + 16'd1;
        else stall_raw_cnt <= stall_raw_cnt;
      end else if (stall_s && !unit_ready_s) begin
        if (stall_fu_cnt != 16'hFFFF) stall_fu_cnt <= stall_fu_cnt + 16'd1;
        else stall_fu_cnt <= stall_fu_cnt;
      end else begin
        stall_raw_cnt <= stall_raw_cnt;
        stall_fu_cnt  <= stall_fu_cnt;
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler; the bench owns a model of
// the dispatch queue and pops it whenever q_r_en is seen high before an edge.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           q_empty;
  decoded_instr_t q_instr;
  logic           q_r_en;
  logic           flush;
  logic           lsu_ready;
  logic           wb0_valid;
  logic [4:0]     wb0_rd;
  logic           wb1_valid;
  logic [4:0]     wb1_rd;
  logic           issue_valid;
  decoded_instr_t issue_instr;
  logic [1:0]     issue_fu;
  logic [15:0]    stall_raw_cnt;
  logic [15:0]    stall_fu_cnt;

  decoded_instr_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int npops    = 0;

  issue_scheduler #(.NUM_REGS(32), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_instr(q_instr), .q_r_en(q_r_en),
    .flush(flush), .lsu_ready(lsu_ready),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_fu(issue_fu),
    .stall_raw_cnt(stall_raw_cnt), .stall_fu_cnt(stall_fu_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decoded_instr_t mk(input logic [7:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic wen, input logic [1:0] fu);
    decoded_instr_t d;
    d.op = op; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.rd_wen = wen; d.fu_sel = fu;
    return d;
  endfunction

  task automatic update_q();
    q_empty = (q.size() == 0);
    q_instr = (q.size() == 0) ? decoded_instr_t'(0) : q[0];
  endtask

  task automatic push(input decoded_instr_t d);
    q.push_back(d);
    update_q();
  endtask

  // One clock: sample the pop request before the edge, apply it after.
  task automatic step();
    logic pop;
    #1;
    pop = q_r_en;
    @(posedge clk);
    #1;
    if (pop) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL pop_when_empty: q_r_en=1 with empty queue, required 0");
        n_fail++;
      end else begin
        void'(q.pop_front());
      end
      npops++;
    end
    update_q();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; lsu_ready = 1'b1;
    wb0_valid = 1'b0; wb0_rd = 5'd0; wb1_valid = 1'b0; wb1_rd = 5'd0;
    q.delete();
    update_q();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (issue_valid !== 1'b0) begin $display("FAIL reset_issue_valid: got %b required 0", issue_valid); n_fail++; end
    n_checks++; if (issue_instr !== decoded_instr_t'(0)) begin $display("FAIL reset_issue_instr: got %h required 0", issue_instr); n_fail++; end
    n_checks++; if (issue_fu !== 2'd0) begin $display("FAIL reset_issue_fu: got %0d required 0", issue_fu); n_fail++; end
    n_checks++; if (stall_raw_cnt !== 16'd0 || stall_fu_cnt !== 16'd0) begin $display("FAIL reset_counters: got raw=%0d fu=%0d required 0/0", stall_raw_cnt, stall_fu_cnt); n_fail++; end
    n_checks++; if (q_r_en !== 1'b0) begin $display("FAIL reset_q_r_en: got %b required 0", q_r_en); n_fail++; end
  endtask

  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 4; i++) push(mk(8'(16 + i), 5'd0, 5'd0, 5'(i + 1), 1'b1, 2'd0));
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (q_r_en !== 1'b1) begin $display("FAIL indep_pop%0d: got q_r_en=%b required 1", i, q_r_en); n_fail++; end
      step();
      n_checks++; if (issue_valid !== 1'b1 || issue_instr.rd !== 5'(i + 1)) begin $display("FAIL indep_issue%0d: got valid=%b rd=%0d required 1/%0d", i, issue_valid, issue_instr.rd, i + 1); n_fail++; end
    end
    step();
    n_checks++; if (issue_valid !== 1'b0) begin $display("FAIL indep_idle: got issue_valid=%b required 0", issue_valid); n_fail++; end
    n_checks++; if (stall_raw_cnt !== 16'd0 || stall_fu_cnt !== 16'd0) begin $display("FAIL indep_counters: got raw=%0d fu=%0d required 0/0", stall_raw_cnt, stall_fu_cnt); n_fail++; end
  endtask

  // Registers 1..4 were left busy; a reset must forget them.
  task automatic test_reset_mid();
    do_reset();
    push(mk(8'h31, 5'd1, 5'd2, 5'd3, 1'b1, 2'd0));
    #1;
    n_checks++; if (q_r_en !== 1'b1) begin $display("FAIL reset_mid_pop: got q_r_en=%b required 1", q_r_en); n_fail++; end
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h31) begin $display("FAIL reset_mid_issue: got valid=%b op=%h required 1/31", issue_valid, issue_instr.op); n_fail++; end
  endtask

  task automatic test_raw();
    do_reset();
    push(mk(8'h21, 5'd0, 5'd0, 5'd5, 1'b1, 2'd0));
    push(mk(8'h22, 5'd5, 5'd0, 5'd6, 1'b1, 2'd0));
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h21) begin $display("FAIL raw_first: got valid=%b op=%h required 1/21", issue_valid, issue_instr.op); n_fail++; end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (q_r_en !== 1'b0) begin $display("FAIL raw_stall%0d: got q_r_en=%b required 0", i, q_r_en); n_fail++; end
      step();
    end
    wb0_valid = 1'b1; wb0_rd = 5'd5;
    #1;
    n_checks++; if (q_r_en !== 1'b1) begin $display("FAIL raw_bypass: got q_r_en=%b required 1", q_r_en); n_fail++; end
    step();
    wb0_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h22) begin $display("FAIL raw_second: got valid=%b op=%h required 1/22", issue_valid, issue_instr.op); n_fail++; end
    n_checks++; if (stall_raw_cnt !== 16'd2 || stall_fu_cnt !== 16'd0) begin $display("FAIL raw_counters: got raw=%0d fu=%0d required 2/0", stall_raw_cnt, stall_fu_cnt); n_fail++; end
  endtask

  task automatic test_set_wins();
    do_reset();
    push(mk(8'h41, 5'd0, 5'd0, 5'd11, 1'b1, 2'd0));
    push(mk(8'h42, 5'd0, 5'd11, 5'd12, 1'b1, 2'd0));
    wb1_valid = 1'b1; wb1_rd = 5'd11;
    step();
    wb1_valid = 1'b0;
    #1;
    n_checks++; if (q_r_en !== 1'b0) begin $display("FAIL setwins_stall: got q_r_en=%b required 0", q_r_en); n_fail++; end
    step();
    n_checks++; if (stall_raw_cnt !== 16'd1) begin $display("FAIL setwins_raw: got %0d required 1", stall_raw_cnt); n_fail++; end
    wb1_valid = 1'b1; wb1_rd = 5'd11;
    step();
    wb1_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h42) begin $display("FAIL setwins_issue: got valid=%b op=%h required 1/42", issue_valid, issue_instr.op); n_fail++; end
  endtask

  task automatic test_mul();
    int gap;
    do_reset();
    push(mk(8'h51, 5'd0, 5'd0, 5'd7, 1'b1, 2'd1));
    push(mk(8'h52, 5'd0, 5'd0, 5'd8, 1'b1, 2'd1));
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd1) begin $display("FAIL mul_first: got valid=%b fu=%0d required 1/1", issue_valid, issue_fu); n_fail++; end
    gap = 0;
    #1;
    while (q_r_en !== 1'b1 && gap < 10) begin step(); gap++; #1; end
    n_checks++; if (gap != 3) begin $display("FAIL mul_gap: got %0d stall cycles required 3", gap); n_fail++; end
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h52 || issue_fu !== 2'd1) begin $display("FAIL mul_second: got valid=%b op=%h fu=%0d required 1/52/1", issue_valid, issue_instr.op, issue_fu); n_fail++; end
    n_checks++; if (stall_fu_cnt !== 16'd3 || stall_raw_cnt !== 16'd0) begin $display("FAIL mul_counters: got fu=%0d raw=%0d required 3/0", stall_fu_cnt, stall_raw_cnt); n_fail++; end
  endtask

  task automatic test_lsu();
    int seen;
    do_reset();
    lsu_ready = 1'b0;
    push(mk(8'h61, 5'd0, 5'd0, 5'd9, 1'b1, 2'd2));
    seen = 0;
    for (int i = 0; i < 5; i++) begin step(); if (issue_valid !== 1'b0) seen++; end
    n_checks++; if (seen != 0 || q.size() != 1) begin $display("FAIL lsu_hold: got %0d issues, queue=%0d required 0/1", seen, q.size()); n_fail++; end
    n_checks++; if (stall_fu_cnt !== 16'd5) begin $display("FAIL lsu_stall: got %0d required 5", stall_fu_cnt); n_fail++; end
    lsu_ready = 1'b1;
    #1;
    n_checks++; if (q_r_en !== 1'b1) begin $display("FAIL lsu_ready_pop: got q_r_en=%b required 1", q_r_en); n_fail++; end
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd2) begin $display("FAIL lsu_issue: got valid=%b fu=%0d required 1/2", issue_valid, issue_fu); n_fail++; end
  endtask

  task automatic test_flush();
    int p0, k, seen;
    do_reset();
    for (int i = 0; i < 6; i++) push(mk(8'(8'h70 + i), 5'd0, 5'd0, 5'(13 + i), 1'b1, 2'd0));
    p0 = npops; seen = 0;
    flush = 1'b1;
    #1;
    n_checks++; if (q_r_en !== 1'b0) begin $display("FAIL flush_enter_pop: got q_r_en=%b required 0", q_r_en); n_fail++; end
    step(); if (issue_valid !== 1'b0) seen++;
    step(); if (issue_valid !== 1'b0) seen++;
    flush = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 20) begin step(); k++; if (issue_valid !== 1'b0) seen++; end
    n_checks++; if (npops - p0 != 6 || q.size() != 0) begin $display("FAIL flush_drain: got %0d pops, queue=%0d required 6/0", npops - p0, q.size()); n_fail++; end
    n_checks++; if (seen != 0) begin $display("FAIL flush_no_issue: got %0d issue cycles required 0", seen); n_fail++; end
    step();
    push(mk(8'h7F, 5'd0, 5'd0, 5'd20, 1'b1, 2'd0));
    #1;
    n_checks++; if (q_r_en !== 1'b1) begin $display("FAIL flush_return: got q_r_en=%b required 1", q_r_en); n_fail++; end
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h7F) begin $display("FAIL flush_resume: got valid=%b op=%h required 1/7f", issue_valid, issue_instr.op); n_fail++; end
    n_checks++; if (stall_raw_cnt !== 16'd0 || stall_fu_cnt !== 16'd0) begin $display("FAIL flush_counters: got raw=%0d fu=%0d required 0/0", stall_raw_cnt, stall_fu_cnt); n_fail++; end
  endtask

  task automatic test_illegal();
    do_reset();
    push(mk(8'h81, 5'd0, 5'd0, 5'd1, 1'b1, 2'd3));
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (q.size() != 1 || stall_fu_cnt !== 16'd4) begin $display("FAIL illegal_stall: got queue=%0d fu=%0d required 1/4", q.size(), stall_fu_cnt); n_fail++; end
    flush = 1'b1;
    step(); step();
    flush = 1'b0;
    step();
    n_checks++; if (q.size() != 0 || stall_fu_cnt !== 16'd4) begin $display("FAIL illegal_flush: got queue=%0d fu=%0d required 0/4", q.size(), stall_fu_cnt); n_fail++; end
  endtask

  task automatic test_x0();
    do_reset();
    push(mk(8'h91, 5'd0, 5'd0, 5'd0, 1'b1, 2'd0));
    push(mk(8'h92, 5'd0, 5'd0, 5'd0, 1'b1, 2'd0));
    step();
    #1;
    n_checks++; if (q_r_en !== 1'b1) begin $display("FAIL x0_not_busy: got q_r_en=%b required 1", q_r_en); n_fail++; end
    step();
    n_checks++; if (issue_valid !== 1'b1 || issue_instr.op !== 8'h92 || stall_raw_cnt !== 16'd0) begin $display("FAIL x0_issue: got valid=%b op=%h raw=%0d required 1/92/0", issue_valid, issue_instr.op, stall_raw_cnt); n_fail++; end
  endtask

  task automatic test_saturation();
    do_reset();
    push(mk(8'hA1, 5'd0, 5'd0, 5'd10, 1'b1, 2'd0));
    push(mk(8'hA2, 5'd10, 5'd0, 5'd11, 1'b1, 2'd0));
    step();
    for (int i = 0; i < 70000; i++) step();
    n_checks++; if (stall_raw_cnt !== 16'hFFFF || stall_fu_cnt !== 16'd0) begin $display("FAIL saturation: got raw=%h fu=%h required ffff/0000", stall_raw_cnt, stall_fu_cnt); n_fail++; end
    n_checks++; if (q.size() != 1) begin $display("FAIL saturation_hold: got queue=%0d required 1", q.size()); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_reset_mid();
    test_raw();
    test_set_wins();
    test_mul();
    test_lsu();
    test_flush();
    test_illegal();
    test_x0();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
